nx_ram_1rw_req: RTL and testbench
=================================

# nx_ram_1rw_req

Request-side initiator for the single-port RAM wrapper (cs/we/add/din/bwe in, registered dout out, one-cycle read latency). It accepts read/write requests on a valid/ready channel and drives the RAM port. It returns read data on a flow-controlled response channel without ever dropping a word, and can optionally zero-fill the whole array after reset. Sits between datapath engines and each `nx_ram_1rw` instance.

## Interface
- `WIDTH`, 64: data width.
- `DEPTH`, 32768: RAM words.
- `AW`, 15: address width, equals clog2(DEPTH).
- `RSP_DEPTH`, 2: response FIFO entries. Minimum 2.
- `INIT_ZERO`, 1: 1 = zero-fill the RAM after reset; 0 = skip.
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid` & `req_ready`.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  AW  word address.
- `req_wdata`  in  WIDTH  write data.
- `req_bwe`  in  WIDTH  per-bit write enable.
- `rsp_valid`  out  1  read data available.
- `rsp_ready`  in  1  consumer takes data when `rsp_valid` & `rsp_ready`.
- `rsp_data`  out  WIDTH  read data, in request order.
- `init_done`  out  1  high once the block is in RUN.
- `ram_cs`, `ram_we`  out  1  RAM chip select and write enable.
- `ram_add`  out  AW  RAM address.
- `ram_din`, `ram_bwe`  out  WIDTH  RAM write data and bit enables.
- `ram_dout`  in  WIDTH  RAM registered read data.

## Operation
- FSM states are IDLE, INIT and RUN. Reset enters IDLE.
  - IDLE lasts exactly 1 cycle, then goes to INIT if `INIT_ZERO`=1, else to RUN.
  - INIT: an address counter `icnt` runs 0..DEPTH-1, one write per cycle: `ram_cs`=1, `ram_we`=1, `ram_add`=`icnt`, `ram_din`=0, `ram_bwe`=all ones.
  - INIT goes to RUN in the cycle after the write to DEPTH-1.
  - RUN is terminal until reset.
- `init_done` = (state==RUN), registered.
- `req_ready` is 0 in IDLE and INIT.
- In RUN, `req_ready` = (`pend` + `fcnt` − (`rsp_valid` & `rsp_ready`) < RSP_DEPTH). This holds for reads and writes alike.
  - `pend` is the 1-bit read-in-flight flag.
  - `fcnt` is the FIFO occupancy.
  - The path from `rsp_ready` to `req_ready` is combinational by design.
  - `req_ready` never depends on `req_valid` or `req_we`.
- In RUN, the RAM port is driven combinationally from the accepted request:
  - `ram_cs` = `req_valid` & `req_ready`.
  - `ram_we` = `req_we`, `ram_add` = `req_addr`, `ram_din` = `req_wdata`, `ram_bwe` = `req_bwe`.
- When `ram_cs`=0, `ram_we`, `ram_add`, `ram_din` and `ram_bwe` are forced to 0.
- On an accepted read, `pend` is set for the next cycle. With `pend`=1, `ram_dout` is pushed into the response FIFO at the next edge.
- Accepted writes produce no response.
- Response FIFO:
  - Order is preserved.
  - A push and a pop in the same cycle leave `fcnt` unchanged.
  - `rsp_data` is the head entry. It must hold stable while `rsp_valid` & !`rsp_ready`.
- By construction a push never hits a full FIFO. Overflow is a design error; the bench asserts it never happens.
- Reset mid-operation: FSM returns to IDLE, `pend` and `fcnt` clear, and queued responses are discarded.
  - An in-progress INIT restarts at address 0.
  - RAM contents are not otherwise touched.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `init_done`=0, `ram_cs`=0, `ram_we`=0, `ram_add`=0, `ram_din`=0, `ram_bwe`=0.
- INIT length is exactly DEPTH cycles.
  - With `INIT_ZERO`=1, `init_done` rises DEPTH+1 cycles after `rst_n` deasserts: 1 IDLE cycle, then DEPTH INIT cycles.
  - With `INIT_ZERO`=0, it rises after 1 cycle.
- Read latency: request accepted at edge E0, push at E1, `rsp_valid`=1 after E1. That is 2 cycles from request to response.
- Throughput is 1 request per cycle sustained while `rsp_ready`=1.
- With `rsp_ready` held 0, at most RSP_DEPTH reads are accepted. `req_ready` then stays 0 until a pop occurs.
- Read-after-write to the same address in consecutive cycles returns the new data, because RAM writes complete at the accepting edge.

## Test plan
- Reset release, `INIT_ZERO`=1, DEPTH=16 override:
  - Expect 16 consecutive writes to addresses 0..15 with din=0 and bwe=all ones.
  - `init_done` rises 17 cycles after release.
  - Reads of all 16 addresses return 0.
- Write 0xDEADBEEF_00000001 to address 5, then read address 5 in the next cycle, `rsp_ready`=1 → `rsp_valid` 2 cycles after the read with data 0xDEADBEEF_00000001.
- Partial write: full write 0xFFFF_FFFF_FFFF_FFFF to address 3, then `bwe`=0x0000_0000_FFFF_FFFF with data 0 → a read of address 3 returns 0xFFFF_FFFF_0000_0000.
- Back-pressure: `rsp_ready`=0, 4 back-to-back reads offered.
  - Only 2 are accepted and `req_ready` drops.
  - Raising `rsp_ready` drains the data in order and the remaining 2 reads are accepted.
  - Same-cycle push/pop is exercised.
- Streaming: 100 reads back-to-back with `rsp_ready`=1 → 100 responses in order, and `req_ready` never deasserts.
- Assert `rst_n` mid-INIT and with 2 queued responses → `rsp_valid`=0 and `init_done`=0 immediately; INIT restarts from address 0.

Source files
------------

// File: rtl/nx_ram_1rw_req.sv
// Request-side initiator for a single-port RAM: valid/ready requests in,
// RAM port out, in-order read data returned through a small response FIFO.
module nx_ram_1rw_req #(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 32768,
  parameter int AW        = 15,
  parameter int RSP_DEPTH = 2,
  parameter int INIT_ZERO = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [WIDTH-1:0] req_bwe,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             init_done,
  output logic             ram_cs,
  output logic             ram_we,
  output logic [AW-1:0]    ram_add,
  output logic [WIDTH-1:0] ram_din,
  output logic [WIDTH-1:0] ram_bwe,
  input  logic [WIDTH-1:0] ram_dout
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = $clog2(RSP_DEPTH);

  typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

  state_t                          state, state_nxt;
  logic [AW-1:0]                   icnt;
  logic                            pend;
  logic [CW-1:0]                   fcnt;
  logic [PW-1:0]                   rptr, wptr;
  logic [RSP_DEPTH-1:0][WIDTH-1:0] mem;
  logic                            push, pop, rd_acc;
  logic [CW:0]                     occ;

  assign rsp_valid = (fcnt != '0);
  assign rsp_data  = mem[rptr];
  assign pop       = rsp_valid & rsp_ready;
  assign push      = pend;
  assign rd_acc    = req_valid & req_ready & ~req_we;

  // Occupancy the FIFO will have once the in-flight read lands, net of this
  // cycle's pop; keeps every accepted read guaranteed a free slot.
  assign occ = {1'b0, fcnt} + {{CW{1'b0}}, pend} - {{CW{1'b0}}, pop};

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_add   = '0;
    ram_din   = '0;
    ram_bwe   = '0;
    case (state)
      IDLE: state_nxt = (INIT_ZERO != 0) ? INIT : RUN;
      INIT: begin
        ram_cs  = 1'b1;
        ram_we  = 1'b1;
        ram_add = icnt;
        ram_bwe = '1;
        if (icnt == AW'(DEPTH - 1)) state_nxt = RUN;
      end
      RUN: begin
        req_ready = (occ < (CW+1)'(RSP_DEPTH));
        if (req_valid && req_ready) begin
          ram_cs  = 1'b1;
          ram_we  = req_we;
          ram_add = req_addr;
          ram_din = req_wdata;
          ram_bwe = req_bwe;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      init_done <= 1'b0;
      icnt      <= '0;
      pend      <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_done <= (state_nxt == RUN);
      icnt      <= (state == INIT) ? icnt + AW'(1) : '0;
      pend      <= rd_acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt <= '0;
      rptr <= '0;
      wptr <= '0;
      mem  <= '0;
    end else begin
      fcnt <= fcnt + CW'(push) - CW'(pop);
      if (push) begin
        mem[wptr] <= ram_dout;
        wptr      <= (wptr == PW'(RSP_DEPTH - 1)) ? '0 : wptr + PW'(1);
      end
      if (pop)
        rptr <= (rptr == PW'(RSP_DEPTH - 1)) ? '0 : rptr + PW'(1);
    end
  end

endmodule

// File: tb/tb_nx_ram_1rw_req.sv
// Directed bench for nx_ram_1rw_req with a 16-word behavioural RAM and a
// queue of expected read responses.
module tb_nx_ram_1rw_req;

  localparam int W = 64;
  localparam int D = 16;
  localparam int A = 4;

  logic          clk = 0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we;
  logic [A-1:0]  req_addr;
  logic [W-1:0]  req_wdata, req_bwe;
  logic          rsp_valid, rsp_ready;
  logic [W-1:0]  rsp_data;
  logic          init_done, ram_cs, ram_we;
  logic [A-1:0]  ram_add;
  logic [W-1:0]  ram_din, ram_bwe, ram_dout;

  logic [W-1:0]  ram_mem [D];
  logic [W-1:0]  sh [D];
  logic [W-1:0]  expq [$];
  logic [W-1:0]  cur_exp;
  int            errors = 0;
  int            checks = 0;

  nx_ram_1rw_req #(.WIDTH(W), .DEPTH(D), .AW(A), .RSP_DEPTH(2), .INIT_ZERO(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_bwe(req_bwe),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .init_done(init_done),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_add(ram_add),
    .ram_din(ram_din), .ram_bwe(ram_bwe), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) ram_mem[ram_add] <= (ram_mem[ram_add] & ~ram_bwe) | (ram_din & ram_bwe);
      else        ram_dout <= ram_mem[ram_add];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Records accepted reads, checks popped data in order, then advances one edge.
  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      if (req_valid && req_ready && !req_we) expq.push_back(cur_exp);
      if (rsp_valid && rsp_ready) begin
        checks++;
        assert (expq.size() > 0) else begin
          errors++;
          $error("FAIL rsp_unexpected observed=%h expected=none", rsp_data);
        end
        if (expq.size() > 0) chk("rsp_order", rsp_data, expq.pop_front());
      end
      chk("fifo_no_ovf", W'(dut.pend && dut.fcnt == 2 && !(rsp_valid && rsp_ready)), '0);
    end
    @(posedge clk); #1;
  endtask

  task automatic wr(input int a, input logic [W-1:0] d, input logic [W-1:0] b);
    req_valid = 1; req_we = 1; req_addr = A'(a); req_wdata = d; req_bwe = b;
    sh[a] = (sh[a] & ~b) | (d & b);
  endtask

  task automatic rd(input int a);
    req_valid = 1; req_we = 0; req_addr = A'(a); req_wdata = '0; req_bwe = '0;
    cur_exp = sh[a];
  endtask

  task automatic idle();
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_bwe = '0;
  endtask

  task automatic init_seq(input string tag);
    for (int k = 0; k < D; k++) begin
      chk({tag, "_add"}, W'(ram_add), W'(k));
      chk({tag, "_cs_we"}, W'({ram_cs, ram_we}), W'(2'b11));
      chk({tag, "_din"}, ram_din, '0);
      chk({tag, "_bwe"}, ram_bwe, '1);
      chk({tag, "_done_lo"}, W'(init_done), '0);
      tick();
    end
    chk({tag, "_done"}, W'(init_done), W'(1));
  endtask

  initial begin
    rst_n = 0; rsp_ready = 1; cur_exp = '0;
    idle();
    for (int i = 0; i < D; i++) sh[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", W'(req_ready), '0);
    chk("rst_rsp_valid", W'(rsp_valid), '0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_init_done", W'(init_done), '0);
    chk("rst_ram_cs_we", W'({ram_cs, ram_we}), '0);
    chk("rst_ram_add", W'(ram_add), '0);
    chk("rst_ram_din", ram_din, '0);
    chk("rst_ram_bwe", ram_bwe, '0);

    // Release: one IDLE cycle, then 16 zero writes, init_done after edge 17.
    rst_n = 1; #1;
    chk("idle_cs", W'(ram_cs), '0);
    chk("idle_ready", W'(req_ready), '0);
    tick();
    init_seq("init");
    chk("run_ready", W'(req_ready), W'(1));

    for (int a = 0; a < D; a++) begin rd(a); tick(); end
    idle(); tick(); tick();
    chk("zero_drain", W'(expq.size()), '0);

    // Write then read-after-write, response 2 cycles after the read.
    wr(5, 64'hDEADBEEF_00000001, '1); #1;
    chk("wr_cs_we", W'({ram_cs, ram_we}), W'(2'b11));
    chk("wr_add", W'(ram_add), W'(5));
    chk("wr_din", ram_din, 64'hDEADBEEF_00000001);
    tick();
    rd(5); #1;
    chk("rd_cs_we", W'({ram_cs, ram_we}), W'(2'b10));
    tick();
    idle(); #1;
    chk("gated_add", W'(ram_add), '0);
    chk("gated_din", ram_din, '0);
    chk("lat_valid_lo", W'(rsp_valid), '0);
    tick();
    chk("lat_valid_hi", W'(rsp_valid), W'(1));
    chk("lat_data", rsp_data, 64'hDEADBEEF_00000001);
    tick();

    // Partial write under bit enables.
    wr(3, '1, '1); tick();
    wr(3, '0, 64'h0000_0000_FFFF_FFFF); tick();
    rd(3); tick();
    idle(); tick();
    chk("partial_data", rsp_data, 64'hFFFF_FFFF_0000_0000);
    tick();
    chk("partial_drain", W'(expq.size()), '0);

    // Back-pressure: only two reads accepted while rsp_ready is low.
    wr(7, 64'h7777_7777_7777_7777, '1); tick();
    wr(9, 64'h9999_9999_9999_9999, '1); tick();
    rsp_ready = 0;
    rd(3); #1; chk("bp_rdy1", W'(req_ready), W'(1)); tick();
    rd(5); #1; chk("bp_rdy2", W'(req_ready), W'(1)); tick();
    rd(7); #1; chk("bp_rdy3", W'(req_ready), '0);   tick();
    chk("bp_rdy4", W'(req_ready), '0);
    chk("bp_valid", W'(rsp_valid), W'(1));
    chk("bp_head", rsp_data, 64'hFFFF_FFFF_0000_0000);
    tick();
    chk("bp_hold", rsp_data, 64'hFFFF_FFFF_0000_0000);
    rsp_ready = 1; #1;
    chk("bp_rdy_pop", W'(req_ready), W'(1));
    tick();
    rd(9); #1; chk("bp_rdy5", W'(req_ready), W'(1)); tick();
    idle();
    chk("bp_pushpop_valid", W'(rsp_valid), W'(1));
    chk("bp_pushpop_data", rsp_data, 64'h7777_7777_7777_7777);
    tick(); tick(); tick();
    chk("bp_drain", W'(expq.size()), '0);

    // Streaming: 100 reads back to back with no stall.
    for (int a = 0; a < D; a++) begin
      wr(a, 64'h0123_4567_89AB_CDEF ^ (W'(a) * 64'h0101_0101_0101_0101), '1);
      tick();
    end
    for (int i = 0; i < 100; i++) begin
      rd(i % D); #1;
      chk("stream_rdy", W'(req_ready), W'(1));
      tick();
    end
    idle(); tick(); tick();
    chk("stream_drain", W'(expq.size()), '0);

    // Reset with two queued responses.
    rsp_ready = 0;
    rd(1); tick(); rd(2); tick(); idle(); tick();
    chk("q2_valid", W'(rsp_valid), W'(1));
    rst_n = 0; #1;
    chk("q2_rst_valid", W'(rsp_valid), '0);
    chk("q2_rst_done", W'(init_done), '0);
    chk("q2_rst_data", rsp_data, '0);
    expq.delete();
    rsp_ready = 1;
    tick();
    rst_n = 1; #1;
    chk("q2_idle_cs", W'(ram_cs), '0);
    tick();
    for (int k = 0; k < 6; k++) begin
      chk("mid_add", W'(ram_add), W'(k));
      tick();
    end

    // Reset in the middle of INIT restarts the fill from address 0.
    rst_n = 0; #1;
    chk("mid_rst_cs", W'(ram_cs), '0);
    chk("mid_rst_done", W'(init_done), '0);
    tick();
    rst_n = 1; #1;
    tick();
    init_seq("reinit");
    for (int i = 0; i < D; i++) sh[i] = '0;
    rd(5); tick(); rd(14); tick();
    idle(); tick(); tick();
    chk("reinit_drain", W'(expq.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
